// File: rtl/row_clear_engine.sv
`default_nettype none
// ============================================================================
// Module      : row_clear_engine
// Description : Sequential line-clear engine for a WIDTH x HEIGHT playfield.
//               Scans the board one row per cycle from bottom to top. Full
//               rows are removed, the remaining rows are compacted downward
//               and the freed rows at the top are zero-filled.
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   start        request, sampled only while idle
//   matrix_in    board, row y = bits [y*WIDTH +: WIDTH], row 0 is the top
//   busy         high while scanning or filling
//   done         one-cycle pulse, results valid
//   matrix_out   compacted board, held until the next accepted start
//   score_plus   number of full rows removed
//   cleared_mask bit y set when original row y was full
//
// Revision    : 1.0 - initial release
// ============================================================================
module row_clear_engine #(
  parameter int WIDTH  = 20,
  parameter int HEIGHT = 20,
  parameter int CW     = $clog2(HEIGHT + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [WIDTH*HEIGHT-1:0] matrix_in,
  output logic                    busy,
  output logic                    done,
  output logic [WIDTH*HEIGHT-1:0] matrix_out,
  output logic [CW-1:0]           score_plus,
  output logic [HEIGHT-1:0]       cleared_mask
);

  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);

  logic [1:0]              state_q, state_d;
  logic [WIDTH*HEIGHT-1:0] board_q, board_d;
  logic [RW-1:0]           rd_q, rd_d;
  logic [RW-1:0]           wr_q, wr_d;
  logic [CW-1:0]           score_q, score_d;
  logic [HEIGHT-1:0]       mask_q, mask_d;
  logic [WIDTH-1:0]        cur_row;

  assign cur_row = board_q[int'(rd_q)*WIDTH +: WIDTH];

  always_comb begin
    state_d = state_q;
    board_d = board_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    score_d = score_q;
    mask_d  = mask_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          board_d = matrix_in;
          rd_d    = LAST_ROW;
          wr_d    = LAST_ROW;
          score_d = '0;
          mask_d  = '0;
          state_d = S_SCAN;
        end
      end

      S_SCAN: begin
        if (&cur_row) begin
          score_d      = score_q + CW'(1);
          mask_d[rd_q] = 1'b1;
        end else begin
          // wr never falls below rd, so this in-place copy never overwrites
          // a row that is still waiting to be read.
          board_d[int'(wr_q)*WIDTH +: WIDTH] = cur_row;
          // With no row cleared, wr reaches 0 on the final scan cycle; hold
          // it there instead of wrapping.
          if (wr_q != '0) begin
            wr_d = wr_q - RW'(1);
          end
        end

        if (rd_q == '0) begin
          // Decision uses the updated count so a full row 0 still triggers FILL.
          state_d = (score_d != '0) ? S_FILL : S_DONE;
        end else begin
          rd_d = rd_q - RW'(1);
        end
      end

      S_FILL: begin
        // After the scan, wr = cleared_count - 1, so counting wr down to 0
        // zero-fills exactly as many top rows as were removed.
        board_d[int'(wr_q)*WIDTH +: WIDTH] = '0;
        if (wr_q == '0) begin
          state_d = S_DONE;
        end else begin
          wr_d = wr_q - RW'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      board_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      score_q <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      score_q <= score_d;
      mask_q  <= mask_d;
    end
  end

  assign busy         = (state_q == S_SCAN) || (state_q == S_FILL);
  assign done         = (state_q == S_DONE);
  assign matrix_out   = board_q;
  assign score_plus   = score_q;
  assign cleared_mask = mask_q;

endmodule
`default_nettype wire

// File: tb/tb_row_clear_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_row_clear_engine
// Description : Self-checking bench for row_clear_engine. Expected results are
//               queued when a start is driven and compared when done pulses.
//               Covers a 20x20 instance and a 4x6 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_row_clear_engine;

  typedef struct packed {
    logic [399:0] m;
    logic [4:0]   s;
    logic [19:0]  mk;
    int           lat;
  } exp_t;

  typedef struct packed {
    logic [23:0] m;
    logic [2:0]  s;
    logic [5:0]  mk;
    int          lat;
  } sexp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [399:0] matrix_in;
  logic         busy, done;
  logic [399:0] matrix_out;
  logic [4:0]   score_plus;
  logic [19:0]  cleared_mask;

  logic         s_start;
  logic [23:0]  s_in;
  logic         s_busy, s_done;
  logic [23:0]  s_out;
  logic [2:0]   s_score;
  logic [5:0]   s_mask;

  int total = 0;
  int bad   = 0;

  exp_t  sb[$];
  sexp_t ssb[$];

  always #5 clk = ~clk;

  row_clear_engine #(.WIDTH(20), .HEIGHT(20)) dut (
    .clk(clk), .rst(rst), .start(start), .matrix_in(matrix_in),
    .busy(busy), .done(done), .matrix_out(matrix_out),
    .score_plus(score_plus), .cleared_mask(cleared_mask)
  );

  row_clear_engine #(.WIDTH(4), .HEIGHT(6)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .matrix_in(s_in),
    .busy(s_busy), .done(s_done), .matrix_out(s_out),
    .score_plus(s_score), .cleared_mask(s_mask)
  );

  function automatic logic [399:0] with_row(input logic [399:0] b, input int r,
                                            input logic [19:0] v);
    b[r*20 +: 20] = v;
    return b;
  endfunction

  function automatic logic [399:0] rand_board();
    logic [399:0] b;
    b = '0;
    for (int r = 0; r < 20; r++) b[r*20 +: 20] = 20'($urandom);
    return b;
  endfunction

  // Reference: keep non-full rows in order, packed against the bottom.
  function automatic exp_t model(input logic [399:0] b);
    exp_t e;
    int   w;
    logic [19:0] row;
    e = '0;
    w = 19;
    for (int r = 19; r >= 0; r--) begin
      row = b[r*20 +: 20];
      if (row == 20'hFFFFF) begin
        e.s     = e.s + 5'd1;
        e.mk[r] = 1'b1;
      end else begin
        e.m[w*20 +: 20] = row;
        w--;
      end
    end
    e.lat = 21 + int'(e.s);
    return e;
  endfunction

  // Called at #1 after an edge while the DUT is idle; start is accepted at the
  // next edge (edge 0) and the task returns in cycle 1.
  task automatic launch(input logic [399:0] b, input exp_t e);
    start     = 1'b1;
    matrix_in = b;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Starts in cycle 1; returns in the done cycle. repulse>0 re-drives start
  // with a different board during that cycle.
  task automatic wait_result(input int repulse);
    int   k;
    bit   got;
    exp_t e;
    k   = 1;
    got = 0;
    while (k <= 100 && !got) begin
      if (k == repulse) begin
        start     = 1'b1;
        matrix_in = rand_board();
      end else begin
        start = 1'b0;
      end
      if (done) begin
        got = 1;
      end else begin
        total++;
        if (busy !== 1'b1) begin
          bad++;
          $display("FAIL busy_during_op cycle %0d: got %b want 1", k, busy);
        end
        @(posedge clk); #1;
        k++;
      end
    end
    start = 1'b0;
    total++;
    if (!got || sb.size() == 0) begin
      bad++;
      $display("FAIL done_timeout: got no done/expectation (queue=%0d) want done", sb.size());
      if (sb.size() != 0) void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    if (k != e.lat) begin
      bad++;
      $display("FAIL latency: got %0d want %0d", k, e.lat);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_in_done: got %b want 0", busy);
    end
    total++;
    if (matrix_out !== e.m) begin
      bad++;
      $display("FAIL matrix_out: got %h want %h", matrix_out, e.m);
    end
    total++;
    if (score_plus !== e.s) begin
      bad++;
      $display("FAIL score_plus: got %0d want %0d", score_plus, e.s);
    end
    total++;
    if (cleared_mask !== e.mk) begin
      bad++;
      $display("FAIL cleared_mask: got %h want %h", cleared_mask, e.mk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; matrix_in = '0; s_start = 1'b0; s_in = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, done, score_plus, cleared_mask} !== '0 || matrix_out !== '0) begin
      bad++;
      $display("FAIL reset_big: got busy=%b done=%b score=%0d mask=%h out=%h want zeros",
               busy, done, score_plus, cleared_mask, matrix_out);
    end
    total++;
    if ({s_busy, s_done, s_score, s_mask, s_out} !== '0) begin
      bad++;
      $display("FAIL reset_small: got busy=%b done=%b score=%0d mask=%h out=%h want zeros",
               s_busy, s_done, s_score, s_mask, s_out);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_empty();
    exp_t e;
    e = '0;
    e.lat = 21;
    launch('0, e);
    wait_result(0);
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse_width: got %b want 0", done);
    end
  endtask

  task automatic test_one_full();
    exp_t e;
    logic [399:0] b;
    b = with_row('0, 19, 20'hFFFFF);
    b = with_row(b, 18, 20'h5A5A5);
    e = '0;
    e.m   = with_row('0, 19, 20'h5A5A5);
    e.s   = 5'd1;
    e.mk  = 20'h80000;
    e.lat = 22;
    launch(b, e);
    wait_result(0);
    @(posedge clk); #1;
  endtask

  task automatic two_full(output logic [399:0] b, output exp_t e);
    b = with_row('0, 19, 20'hFFFFF);
    b = with_row(b, 18, 20'h12345);
    b = with_row(b, 17, 20'hFFFFF);
    b = with_row(b, 16, 20'h0F0F0);
    e = '0;
    e.m   = with_row(with_row('0, 19, 20'h12345), 18, 20'h0F0F0);
    e.s   = 5'd2;
    e.mk  = 20'hA0000;
    e.lat = 23;
  endtask

  task automatic test_two_full();
    exp_t e;
    logic [399:0] b;
    two_full(b, e);
    launch(b, e);
    wait_result(0);
    @(posedge clk); #1;
  endtask

  task automatic test_all_full();
    exp_t e;
    e = '0;
    e.s   = 5'd20;
    e.mk  = 20'hFFFFF;
    e.lat = 41;
    launch({400{1'b1}}, e);
    wait_result(0);
    @(posedge clk); #1;
  endtask

  task automatic test_start_ignored();
    exp_t e;
    logic [399:0] b;
    two_full(b, e);
    launch(b, e);
    wait_result(5);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bit seen;
    logic [399:0] b;
    b = with_row(rand_board(), 19, 20'hFFFFF);
    start = 1'b1; matrix_in = b;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({busy, done, score_plus, cleared_mask} !== '0 || matrix_out !== '0) begin
      bad++;
      $display("FAIL reset_mid: got busy=%b done=%b score=%0d mask=%h out=%h want zeros",
               busy, done, score_plus, cleared_mask, matrix_out);
    end
    rst  = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL reset_mid_no_done: got done=1 want no done");
    end
    // Fresh start afterwards, mixed board with forced full rows.
    b = rand_board();
    b = with_row(b, 19, 20'hFFFFF);
    b = with_row(b, 7, 20'hFFFFF);
    b = with_row(b, 0, 20'hFFFFF);
    b = with_row(b, 10, 20'h00000);
    launch(b, model(b));
    wait_result(0);
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    exp_t e1;
    logic [399:0] b1, b2;
    two_full(b1, e1);
    launch(b1, e1);
    wait_result(0);
    // Now in the DONE cycle: this start must be ignored at the coming edge.
    b2 = rand_board();
    b2 = with_row(b2, 12, 20'hFFFFF);
    b2 = with_row(b2, 3, 20'hFFFFF);
    start     = 1'b1;
    matrix_in = b2;
    sb.push_back(model(b2));
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle_gap: got busy=%b done=%b want 0 0", busy, done);
    end
    total++;
    if (matrix_out !== e1.m) begin
      bad++;
      $display("FAIL b2b_hold: got %h want %h", matrix_out, e1.m);
    end
    @(posedge clk); #1;
    start = 1'b0;
    wait_result(0);
    @(posedge clk); #1;
  endtask

  task automatic test_small();
    sexp_t e;
    int    k;
    bit    got;
    e.m   = 24'h380000;
    e.s   = 3'd2;
    e.mk  = 6'b101000;
    e.lat = 9;
    s_start = 1'b1;
    s_in    = 24'hF3F800;
    ssb.push_back(e);
    @(posedge clk); #1;
    s_start = 1'b0;
    k   = 1;
    got = 0;
    while (k <= 40 && !got) begin
      if (s_done) got = 1;
      else begin @(posedge clk); #1; k++; end
    end
    total++;
    if (!got || ssb.size() == 0) begin
      bad++;
      $display("FAIL small_timeout: got no done want done");
      return;
    end
    e = ssb.pop_front();
    if (k != e.lat) begin
      bad++;
      $display("FAIL small_latency: got %0d want %0d", k, e.lat);
    end
    total++;
    if (s_out !== e.m) begin
      bad++;
      $display("FAIL small_matrix: got %h want %h", s_out, e.m);
    end
    total++;
    if (s_score !== e.s) begin
      bad++;
      $display("FAIL small_score: got %0d want %0d", s_score, e.s);
    end
    total++;
    if (s_mask !== e.mk) begin
      bad++;
      $display("FAIL small_mask: got %b want %b", s_mask, e.mk);
    end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_one_full();
    test_two_full();
    test_all_full();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_small();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish before 100000ns");
    $fatal(1);
  end

endmodule
`default_nettype wire
